// File: rtl/spi_pkg.sv
// Shared definitions for the 9-bit SPI link: frame geometry, receiver states
// and link timing common to master and slave.
`timescale 1ns/1ps
package spi_pkg;

   localparam int unsigned SPI_M    = 9;
   localparam int unsigned SPI_CBW  = 4;
   localparam int unsigned SPI_SYNC = 2;

   localparam int unsigned TBIT_NS = 2000;
   localparam int unsigned TCE_NS  = 1000;
   localparam int unsigned TCLK_NS = 20;

   typedef enum logic [1:0] {
      WAIT,
      IDLE,
      SHIFT,
      DONE
   } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// N-flop synchroniser for one asynchronous input, with a history flop
// providing single-cycle rise/fall pulses in the clk domain.
`timescale 1ns/1ps
module spi_sync_edge #(
   parameter int unsigned N       = 2,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_sync,
   output logic o_rise,
   output logic o_fall
);

   logic [N-1:0] r_sync;
   logic         r_hist;

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync <= {N{RST_VAL}};
         r_hist <= RST_VAL;
      end else begin
         r_sync <= {r_sync[N-2:0], i_d};
         r_hist <= r_sync[N-1];
      end
   end

   assign o_sync = r_sync[N-1];
   assign o_rise = r_sync[N-1] & ~r_hist;
   assign o_fall = ~r_sync[N-1] & r_hist;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI frame receiver: oversamples LOAD/SCLK/MOSI in the clk domain, shifts MOSI
// in on SCLK rise, returns DI on MISO, and reports each frame on LOAD rise.
`timescale 1ns/1ps
module spi_slave_rx
   import spi_pkg::*;
#(
   parameter int unsigned M    = SPI_M,
   parameter int unsigned SYNC = SPI_SYNC,
   parameter int unsigned CBW  = SPI_CBW
) (
   input  logic           clk,
   input  logic           clr,
   input  logic           LOAD,
   input  logic           SCLK,
   input  logic           MOSI,
   output logic           MISO,
   input  logic [M-1:0]   DI,
   output logic [M-1:0]   DO,
   output logic           DO_VALID,
   output logic           ERR,
   output logic [CBW-1:0] cb_bit,
   output logic           busy
);

   localparam int unsigned SW = $clog2(SYNC + 2);

   state_t r_state, w_state_nxt;

   logic            w_load_sync, w_load_rise, w_load_fall;
   logic            w_unused_sclk_sync, w_sclk_rise, w_sclk_fall;
   logic [SYNC-1:0] r_mosi_sync;
   logic            w_mosi;
   logic [SW-1:0]   r_settle;
   logic            w_settled;

   logic [M-1:0]    r_rx;
   logic [M-2:0]    r_tx;
   logic            r_miso;
   logic [M-1:0]    r_do;
   logic            r_err;
   logic [CBW-1:0]  r_cb;

   spi_sync_edge #(.N(SYNC), .RST_VAL(1'b1)) u_load_sync (
      .clk    (clk),
      .i_rst  (clr),
      .i_d    (LOAD),
      .o_sync (w_load_sync),
      .o_rise (w_load_rise),
      .o_fall (w_load_fall)
   );

   spi_sync_edge #(.N(SYNC), .RST_VAL(1'b0)) u_sclk_sync (
      .clk    (clk),
      .i_rst  (clr),
      .i_d    (SCLK),
      .o_sync (w_unused_sclk_sync),
      .o_rise (w_sclk_rise),
      .o_fall (w_sclk_fall)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr) r_mosi_sync <= '0;
      else     r_mosi_sync <= {r_mosi_sync[SYNC-2:0], MOSI};
   end
   assign w_mosi = r_mosi_sync[SYNC-1];

   // LOAD resets to 1 in the synchroniser, so WAIT only trusts it once real
   // samples have flushed through the pipeline and history flop.
   assign w_settled = (r_settle == SW'(SYNC + 1));

   always_ff @(posedge clk or posedge clr) begin
      if (clr) r_state <= WAIT;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      DO_VALID    = 1'b0;
      case (r_state)
         WAIT:  if (w_settled && w_load_sync) w_state_nxt = IDLE;
         IDLE:  if (w_load_fall) w_state_nxt = SHIFT;
         SHIFT: begin
            busy = 1'b1;
            if (w_load_rise) w_state_nxt = DONE;
         end
         DONE: begin
            DO_VALID    = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = WAIT;
      endcase
   end

   // DO/ERR load on the edge into DONE so they line up with the DO_VALID pulse.
   // The transmit MSB goes straight to MISO; r_tx holds the remaining bits.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_settle <= '0;
         r_rx     <= '0;
         r_tx     <= '0;
         r_miso   <= 1'b0;
         r_do     <= '0;
         r_err    <= 1'b0;
         r_cb     <= '0;
      end else begin
         if (r_state == WAIT && !w_settled) r_settle <= r_settle + 1'b1;
         case (r_state)
            IDLE: begin
               if (w_load_fall) begin
                  r_tx   <= DI[M-2:0];
                  r_miso <= DI[M-1];
                  r_cb   <= '0;
                  r_rx   <= '0;
               end
            end
            SHIFT: begin
               if (w_load_rise) begin
                  r_do  <= r_rx;
                  r_err <= (r_cb != CBW'(M));
               end else if (w_sclk_rise) begin
                  r_rx <= {r_rx[M-2:0], w_mosi};
                  if (r_cb != '1) r_cb <= r_cb + 1'b1;
               end else if (w_sclk_fall) begin
                  r_tx   <= {r_tx[M-3:0], 1'b0};
                  r_miso <= r_tx[M-2];
               end
            end
            DONE:    r_miso <= 1'b0;
            default: ;
         endcase
      end
   end

   assign MISO   = r_miso;
   assign DO     = r_do;
   assign ERR    = r_err;
   assign cb_bit = r_cb;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: a behavioural SPI master drives frames,
// results are compared with a frame-level arithmetic model.
`timescale 1ns/1ps
module tb_spi_slave_rx;
   import spi_pkg::*;

   localparam int HALF_CLK = int'(TBIT_NS / 2 / TCLK_NS);
   localparam int TCE_CLK  = int'(TCE_NS / TCLK_NS);

   logic       clk = 1'b0;
   logic       clr;
   logic       LOAD, SCLK, MOSI;
   logic       MISO;
   logic [8:0] DI;
   logic [8:0] DO;
   logic       DO_VALID, ERR;
   logic [3:0] cb_bit;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int vcnt   = 0;

   spi_slave_rx #(.M(9), .SYNC(2), .CBW(4)) dut (
      .clk      (clk),
      .clr      (clr),
      .LOAD     (LOAD),
      .SCLK     (SCLK),
      .MOSI     (MOSI),
      .MISO     (MISO),
      .DI       (DI),
      .DO       (DO),
      .DO_VALID (DO_VALID),
      .ERR      (ERR),
      .cb_bit   (cb_bit),
      .busy     (busy)
   );

   always #(TCLK_NS / 2) clk = ~clk;

   always @(posedge clk) if (DO_VALID === 1'b1) vcnt++;

   typedef struct {
      logic [15:0] data;
      int          n;
      logic [8:0]  di;
      logic [8:0]  exp_do;
      logic        exp_err;
      logic [3:0]  exp_cb;
      logic [15:0] exp_rx;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Frame-level model: DO keeps the last 9 bits sent, MISO delivers DI MSB
   // first followed by zeros.
   function automatic logic [8:0] model_do(input logic [15:0] d, input int n);
      int unsigned v;
      v = 32'(d) & ((32'd1 << n) - 1);
      return v[8:0];
   endfunction

   function automatic logic [15:0] model_rx(input logic [8:0] di, input int n);
      int unsigned v;
      v = (32'(di) << n) >> 9;
      return v[15:0];
   endfunction

   // Master: sends data[n-1:0] MSB first; with coincide set, LOAD rises together
   // with the last SCLK rising edge.
   task automatic run_frame(input logic [15:0] data, input int n, input logic [8:0] di0,
                            input logic [8:0] di1, input bit coincide,
                            output logic [15:0] rx);
      DI   = di0;
      LOAD = 1'b0;
      rx   = '0;
      for (int k = 0; k < n; k++) begin
         MOSI = data[n-1-k];
         if (k == 4) DI = di1;
         wait_clk(k == 0 ? TCE_CLK : HALF_CLK);
         rx   = {rx[14:0], MISO};
         SCLK = 1'b1;
         if (coincide && k == n - 1) break;
         if (k == 0) chk("busy_in_frame", busy, 1);
         wait_clk(HALF_CLK);
         SCLK = 1'b0;
      end
      if (!coincide) wait_clk(TCE_CLK);
      LOAD = 1'b1;
      wait_clk(2);
      chk("valid_early", DO_VALID, 0);
      wait_clk(1);
      chk("valid_pulse", DO_VALID, 1);
      wait_clk(1);
      chk("valid_end", DO_VALID, 0);
      chk("miso_after", MISO, 0);
      chk("busy_after", busy, 0);
      wait_clk(HALF_CLK);
      SCLK = 1'b0;
      wait_clk(TCE_CLK);
   endtask

   task automatic chk_frame(input string tag, input logic [8:0] edo, input logic eerr,
                            input logic [3:0] ecb, input logic [15:0] erx,
                            input logic [15:0] rx);
      chk({tag, "_do"}, DO, edo);
      chk({tag, "_err"}, ERR, eerr);
      chk({tag, "_cb"}, cb_bit, ecb);
      chk({tag, "_miso_word"}, rx, erx);
   endtask

   initial begin
      logic [15:0] rx, data;
      logic [8:0]  di;
      int          n, v0;

      tbl[0] = '{16'h00F3,  9, 9'h1A5, 9'h0F3, 1'b0, 4'd9,  16'h01A5};
      tbl[1] = '{16'h001F,  5, 9'h1A5, 9'h01F, 1'b1, 4'd5,  16'h001A};
      tbl[2] = '{16'h0ABC, 12, 9'h0F0, 9'h0BC, 1'b1, 4'd12, 16'h0780};
      tbl[3] = '{16'h0000,  9, 9'h1FF, 9'h000, 1'b0, 4'd9,  16'h01FF};
      tbl[4] = '{16'h01FF,  9, 9'h000, 9'h1FF, 1'b0, 4'd9,  16'h0000};
      tbl[5] = '{16'h0001,  1, 9'h100, 9'h001, 1'b1, 4'd1,  16'h0001};
      tbl[6] = '{16'hFFFF, 16, 9'h155, 9'h1FF, 1'b1, 4'd15, 16'hAA80};

      clr = 1'b1; LOAD = 1'b1; SCLK = 1'b0; MOSI = 1'b0; DI = '0;
      wait_clk(3);
      chk("rst_do", DO, 0);
      chk("rst_valid", DO_VALID, 0);
      chk("rst_err", ERR, 0);
      chk("rst_cb", cb_bit, 0);
      chk("rst_busy", busy, 0);
      chk("rst_miso", MISO, 0);
      clr = 1'b0;
      wait_clk(10);

      // SCLK activity with LOAD high is ignored
      for (int i = 0; i < 3; i++) begin
         SCLK = 1'b1; wait_clk(10);
         SCLK = 1'b0; wait_clk(10);
      end
      chk("idle_sclk_valid", vcnt, 0);
      chk("idle_sclk_cb", cb_bit, 0);
      chk("idle_sclk_miso", MISO, 0);
      chk("idle_sclk_busy", busy, 0);

      for (int i = 0; i < 7; i++) begin
         run_frame(tbl[i].data, tbl[i].n, tbl[i].di, tbl[i].di, 1'b0, rx);
         chk_frame($sformatf("tbl%0d", i), tbl[i].exp_do, tbl[i].exp_err,
                   tbl[i].exp_cb, tbl[i].exp_rx, rx);
      end

      // Back-to-back frames, DI changed mid-frame
      run_frame(16'h0155, 9, 9'h0C3, 9'h1FF, 1'b0, rx);
      chk_frame("b2b1", 9'h155, 1'b0, 4'd9, 16'h00C3, rx);
      run_frame(16'h00AA, 9, 9'h1FF, 9'h1FF, 1'b0, rx);
      chk_frame("b2b2", 9'h0AA, 1'b0, 4'd9, 16'h01FF, rx);

      // clr after the 4th SCLK rise, LOAD still low on release
      DI = 9'h0F0; LOAD = 1'b0;
      for (int k = 0; k < 4; k++) begin
         MOSI = k[0];
         wait_clk(HALF_CLK);
         SCLK = 1'b1;
         if (k < 3) begin
            wait_clk(HALF_CLK);
            SCLK = 1'b0;
         end
      end
      wait_clk(5);
      chk("pre_clr_cb", cb_bit, 4);
      v0 = vcnt;
      clr = 1'b1;
      #2;
      chk("clr_busy", busy, 0);
      chk("clr_cb", cb_bit, 0);
      chk("clr_do", DO, 0);
      chk("clr_err", ERR, 0);
      chk("clr_miso", MISO, 0);
      wait_clk(3);
      clr = 1'b0;
      wait_clk(HALF_CLK);
      chk("clr_wait_busy", busy, 0);
      SCLK = 1'b0;
      for (int k = 0; k < 3; k++) begin
         wait_clk(HALF_CLK); SCLK = 1'b1;
         wait_clk(HALF_CLK); SCLK = 1'b0;
      end
      chk("clr_wait_busy2", busy, 0);
      LOAD = 1'b1;
      wait_clk(20);
      chk("clr_no_valid", vcnt, v0);
      chk("clr_idle_busy", busy, 0);
      run_frame(16'h0123, 9, 9'h1A5, 9'h1A5, 1'b0, rx);
      chk_frame("post_clr", 9'h123, 1'b0, 4'd9, 16'h01A5, rx);

      // LOAD rise coincides with the 9th SCLK rise
      data = 16'h01B6;
      run_frame(data, 9, 9'h0F0, 9'h0F0, 1'b1, rx);
      chk("coinc_do", DO, model_do(data >> 1, 8));
      chk("coinc_err", ERR, 1);
      chk("coinc_cb", cb_bit, 8);

      for (int i = 0; i < 12; i++) begin
         data = 16'($urandom);
         n    = $urandom_range(1, 13);
         di   = 9'($urandom);
         run_frame(data, n, di, 9'($urandom), 1'b0, rx);
         chk_frame($sformatf("rnd%0d", i), model_do(data, n), (n != 9), 4'(n),
                   model_rx(di, n), rx);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
